// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: holds predicted branches from fetch, compares them
// against execute outcomes, strobes predictor updates, and issues redirects with flush.
module branch_resolve_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     push_taken,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [ADDR_W-1:0]        push_target,
    input  logic                     resolve,
    input  logic                     actual_taken,
    input  logic [ADDR_W-1:0]        actual_target,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     upd_valid,
    output logic                     misprediction,
    output logic                     redirect,
    output logic [ADDR_W-1:0]        redirect_pc,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispred_cnt,
    output logic                     err_overflow,
    output logic                     err_underflow
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic              taken;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    entry_t            head;
    logic              do_pop;
    logic              do_push;
    logic              dir_miss;
    logic              tgt_miss;
    logic              redir;
    logic              overflow;
    logic [ADDR_W-1:0] next_pc;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        head     = mem[rd_ptr];
        do_pop   = resolve & ~empty;
        dir_miss = head.taken != actual_taken;
        tgt_miss = head.taken & actual_taken & (head.target != actual_target);
        redir    = do_pop & (dir_miss | tgt_miss);
        next_pc  = actual_taken ? actual_target : head.pc + ADDR_W'(4);
        // A full queue can still take a push when a non-redirecting pop frees the head slot.
        do_push  = push & ~redir & (~full | do_pop);
        overflow = push & full & ~do_pop;
    end

    // NOTE: entry storage has no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{taken: push_taken, pc: push_pc, target: push_target};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redir) begin
            // Everything younger than the mispredicted branch is wrong-path.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid     <= 1'b0;
            misprediction <= 1'b0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            branch_cnt    <= '0;
            mispred_cnt   <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            upd_valid     <= do_pop;
            misprediction <= do_pop & dir_miss;
            redirect      <= redir;
            if (redir) redirect_pc <= next_pc;
            if (do_pop && branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (redir && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
            if (overflow) err_overflow <= 1'b1;
            if (resolve && empty) err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push = 1'b0;
    logic              push_taken = 1'b0;
    logic [ADDR_W-1:0] push_pc = '0;
    logic [ADDR_W-1:0] push_target = '0;
    logic              resolve = 1'b0;
    logic              actual_taken = 1'b0;
    logic [ADDR_W-1:0] actual_target = '0;
    logic              full;
    logic              empty;
    logic [2:0]        count;
    logic              upd_valid;
    logic              misprediction;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  mispred_cnt;
    logic              err_overflow;
    logic              err_underflow;

    branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_taken(push_taken), .push_pc(push_pc), .push_target(push_target),
        .resolve(resolve), .actual_taken(actual_taken), .actual_target(actual_target),
        .full(full), .empty(empty), .count(count),
        .upd_valid(upd_valid), .misprediction(misprediction),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } br_t;

    br_t         q[$];
    int          m_bcnt, m_mcnt;
    logic        m_upd, m_mis, m_red, m_of, m_uf;
    logic [31:0] m_rpc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_bcnt = 0; m_mcnt = 0;
        m_upd = 0; m_mis = 0; m_red = 0; m_of = 0; m_uf = 0;
        m_rpc = '0;
    endtask

    // Applies one cycle of the resolve/push rules to the reference queue.
    task automatic model_cycle();
        br_t  e;
        logic flushed = 1'b0;
        logic dm, tm;
        m_upd = 0; m_mis = 0; m_red = 0;
        if (resolve) begin
            if (q.size() == 0) m_uf = 1;
            else begin
                e  = q.pop_front();
                dm = (e.taken != actual_taken);
                tm = e.taken && actual_taken && (e.target != actual_target);
                m_upd = 1; m_mis = dm; m_red = dm || tm;
                m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
                if (m_red) begin
                    m_rpc = actual_taken ? actual_target : e.pc + 32'd4;
                    m_mcnt = (m_mcnt < CMAX) ? m_mcnt + 1 : CMAX;
                    q.delete();
                    flushed = 1'b1;
                end
            end
        end
        if (push && !flushed) begin
            if (q.size() < DEPTH) q.push_back('{taken: push_taken, pc: push_pc, target: push_target});
            else m_of = 1;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".count"},      32'(count),         32'(q.size()));
        check({ctx, ".empty"},      32'(empty),         32'(q.size() == 0));
        check({ctx, ".full"},       32'(full),          32'(q.size() == DEPTH));
        check({ctx, ".upd_valid"},  32'(upd_valid),     32'(m_upd));
        check({ctx, ".mispred"},    32'(misprediction), 32'(m_mis));
        check({ctx, ".redirect"},   32'(redirect),      32'(m_red));
        check({ctx, ".redir_pc"},   redirect_pc,        m_rpc);
        check({ctx, ".branch_cnt"}, 32'(branch_cnt),    32'(m_bcnt));
        check({ctx, ".mispred_cnt"},32'(mispred_cnt),   32'(m_mcnt));
        check({ctx, ".err_of"},     32'(err_overflow),  32'(m_of));
        check({ctx, ".err_uf"},     32'(err_underflow), 32'(m_uf));
    endtask

    task automatic step(input string ctx, input logic p, input logic pt, input logic [31:0] ppc,
                        input logic [31:0] ptg, input logic r, input logic at, input logic [31:0] atg);
        push = p; push_taken = pt; push_pc = ppc; push_target = ptg;
        resolve = r; actual_taken = at; actual_target = atg;
        @(posedge clk);
        #1;
        model_cycle();
        compare_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all(ctx);
        #2 rst = 1'b1;
    endtask

    initial begin
        br_t h;
        logic at;
        logic [31:0] atg;

        push = 0; resolve = 0;
        #3;
        do_reset("reset");
        @(posedge clk); #1;

        // Correct taken prediction
        step("hit_push", 1, 1, 32'h100, 32'h200, 0, 0, 0);
        step("hit_res",  0, 0, 0, 0, 1, 1, 32'h200);
        check("hit_bcnt_const", 32'(branch_cnt), 32'd1);

        // Direction miss, not-taken predicted
        step("dm_push", 1, 0, 32'h40, 32'h0, 0, 0, 0);
        step("dm_res",  0, 0, 0, 0, 1, 1, 32'h80);
        check("dm_rpc_const", redirect_pc, 32'h80);
        step("dm2_push", 1, 1, 32'h40, 32'h90, 0, 0, 0);
        step("dm2_res",  0, 0, 0, 0, 1, 0, 32'h0);
        check("dm2_rpc_const", redirect_pc, 32'h44);

        // Target-only miss flushes younger entries, same-cycle push discarded
        for (int i = 0; i < 3; i++) step("tm_push", 1, 1, 32'h10 + 32'(i*4), 32'h200, 0, 0, 0);
        step("tm_res", 1, 1, 32'h500, 32'h600, 1, 1, 32'h300);
        check("tm_count_const", 32'(count), 32'd0);

        // Fill, overflow, then push+correct resolve at full
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 32'h1000 + 32'(i*4), 0, 0, 0, 0);
        step("ovf", 1, 0, 32'h2000, 0, 0, 0, 0);
        check("ovf_flag_const", 32'(err_overflow), 32'd1);
        step("full_pr", 1, 1, 32'h3000, 32'h3100, 1, 0, 0);
        check("full_pr_count_const", 32'(count), 32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            h = q[0];
            step("drain", 0, 0, 0, 0, 1, h.taken, h.target);
        end

        // Pointer wrap over ordered push/resolve pairs
        step("wrap_first", 1, 1, 32'h4000, 32'h4400, 0, 0, 0);
        for (int i = 1; i < 10; i++) begin
            h = q[0];
            step("wrap", 1, i[0], 32'h4000 + 32'(i*4), 32'h4400 + 32'(i*8), 1, h.taken, h.target);
        end
        h = q[0];
        step("wrap_last", 0, 0, 0, 0, 1, h.taken, h.target);

        // Underflow
        step("uf", 0, 0, 0, 0, 1, 1, 32'h1234);
        check("uf_flag_const", 32'(err_underflow), 32'd1);

        // Asynchronous reset with two entries in flight
        step("pre_rst_a", 1, 1, 32'h50, 32'h60, 0, 0, 0);
        step("pre_rst_b", 1, 0, 32'h54, 32'h0, 0, 0, 0);
        #2;
        do_reset("mid_reset");
        step("post_rst_idle", 0, 0, 0, 0, 0, 0, 0);

        // Saturation of branch_cnt: 17 resolves
        step("sat_first", 1, 1, 32'h700, 32'h800, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            h = q[0];
            step("sat", (i < 16), 1, 32'h700, 32'h800, 1, h.taken, h.target);
        end
        check("sat_bcnt_const", 32'(branch_cnt), 32'd15);

        // Randomized traffic; resolutions agree with the head about half the time
        do_reset("rand_reset");
        for (int i = 0; i < 400; i++) begin
            logic rp, rr, pt;
            rp = ($urandom_range(0, 99) < 60);
            rr = ($urandom_range(0, 99) < 50);
            pt = 1'($urandom);
            if (q.size() > 0 && $urandom_range(0, 99) < 55) begin
                h = q[0]; at = h.taken; atg = h.target;
            end else begin
                at = 1'($urandom); atg = {$urandom_range(0, 15), 2'b00};
            end
            step("rand", rp, pt, 32'($urandom) & 32'hFFFF_FFFC, {$urandom_range(0, 15), 2'b00},
                 rr, at, atg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
